// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver
//
// Sequencer for a cascade of N_CHIPS 74HC595-style shift/storage registers.
// A parallel frame captured on an accepted start_i is shifted out MSB-first on
// si_o/sck_o and then transferred to the storage outputs with an rck_o pulse.
// A clr_req_i clears the shift chain through sclr_n_o and then latches the zeros.
// Every sck/rck/sclr phase lasts CLK_DIV clock cycles.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start_i    one-cycle send request, ignored while busy
//   data_i     frame to send (W = 8*N_CHIPS bits), captured on acceptance
//   clr_req_i  one-cycle clear request, wins over a simultaneous start_i
//   oe_i       output enable request; g_n_o = ~oe_i one cycle later
//   busy_o     sequence in progress
//   done_o     one-cycle pulse when a frame or clear completes
//   si_o       serial data to the first stage
//   sck_o      shift clock
//   rck_o      storage latch clock
//   sclr_n_o   shift-register clear, active low
//   g_n_o      output enable, active low

module hc595_chain_driver #(
    parameter int unsigned N_CHIPS = 2,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [8*N_CHIPS-1:0]   data_i,
    input  logic                   clr_req_i,
    input  logic                   oe_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   si_o,
    output logic                   sck_o,
    output logic                   rck_o,
    output logic                   sclr_n_o,
    output logic                   g_n_o
);

    localparam int unsigned W    = 8 * N_CHIPS;
    localparam int unsigned BitW = $clog2(W);

    localparam logic [7:0]      PhaseLast = 8'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitTop    = BitW'(W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StLatchHi,
        StLatchLo,
        StClear,
        StDone
    } state_e;

    state_e          state_q;
    logic [7:0]      phase_q;
    logic [BitW-1:0] bit_q;
    logic [W-1:0]    buf_q;

    logic busy_q, done_q, si_q, sck_q, rck_q, sclr_n_q, g_n_q;

    logic phase_end;
    assign phase_end = (phase_q == PhaseLast);

    // Pin outputs are decoded from the current state and registered, so they
    // follow the state by one cycle and never glitch.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            bit_q    <= '0;
            buf_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            si_q     <= 1'b0;
            sck_q    <= 1'b0;
            rck_q    <= 1'b0;
            sclr_n_q <= 1'b0;
            g_n_q    <= 1'b1;
        end else begin
            g_n_q <= ~oe_i;

            unique case (state_q)
                StIdle: begin
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    si_q     <= 1'b0;
                    sck_q    <= 1'b0;
                    rck_q    <= 1'b0;
                    sclr_n_q <= 1'b1;
                    phase_q  <= '0;
                    // done_q high marks the externally visible DONE cycle;
                    // requests seen there are dropped.
                    if (!done_q) begin
                        if (clr_req_i) begin
                            state_q <= StClear;
                        end else if (start_i) begin
                            buf_q   <= data_i;
                            bit_q   <= BitTop;
                            state_q <= StShiftLo;
                        end
                    end
                end

                StShiftLo: begin
                    busy_q   <= 1'b1;
                    done_q   <= 1'b0;
                    si_q     <= buf_q[bit_q];
                    sck_q    <= 1'b0;
                    rck_q    <= 1'b0;
                    sclr_n_q <= 1'b1;
                    if (phase_end) begin
                        phase_q <= '0;
                        state_q <= StShiftHi;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end

                StShiftHi: begin
                    busy_q   <= 1'b1;
                    sck_q    <= 1'b1;
                    sclr_n_q <= 1'b1;
                    if (phase_end) begin
                        phase_q <= '0;
                        if (bit_q != '0) begin
                            bit_q   <= bit_q - BitW'(1);
                            state_q <= StShiftLo;
                        end else begin
                            state_q <= StLatchHi;
                        end
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end

                StLatchHi: begin
                    busy_q   <= 1'b1;
                    sck_q    <= 1'b0;
                    rck_q    <= 1'b1;
                    sclr_n_q <= 1'b1;
                    if (phase_end) begin
                        phase_q <= '0;
                        state_q <= StLatchLo;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end

                StLatchLo: begin
                    busy_q   <= 1'b1;
                    rck_q    <= 1'b0;
                    sclr_n_q <= 1'b1;
                    if (phase_end) begin
                        phase_q <= '0;
                        state_q <= StDone;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end

                StClear: begin
                    busy_q   <= 1'b1;
                    done_q   <= 1'b0;
                    si_q     <= 1'b0;
                    sck_q    <= 1'b0;
                    rck_q    <= 1'b0;
                    sclr_n_q <= 1'b0;
                    if (phase_end) begin
                        phase_q <= '0;
                        state_q <= StLatchHi;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end

                StDone: begin
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    si_q     <= 1'b0;
                    sck_q    <= 1'b0;
                    rck_q    <= 1'b0;
                    sclr_n_q <= 1'b1;
                    phase_q  <= '0;
                    state_q  <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign si_o     = si_q;
    assign sck_o    = sck_q;
    assign rck_o    = rck_q;
    assign sclr_n_o = sclr_n_q;
    assign g_n_o    = g_n_q;

endmodule

// File: doc/hc595_chain_driver.md
Name: hc595_chain_driver

Overview:
- Sequencer for a cascade of N_CHIPS 74HC595-style shift/storage registers.
- Accepts a parallel frame on a one-cycle start strobe, then serialises it MSB-first on si/sck and pulses rck to transfer it to the storage outputs.
- Also issues shift-register clears through sclr_n and drives the output-enable g_n.
- Sits between system logic (LED/segment drivers) and the board pins of the 595 chain.

Parameters:
- N_CHIPS, 2, number of cascaded 8-bit stages; frame width W = 8*N_CHIPS
- CLK_DIV, 4, clk cycles per sck/rck half-period; legal values 1..255

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to send data; ignored while busy=1
- data  input  W  frame to send; captured on the accepted start edge
- clr_req  input  1  one-cycle request to clear the chain; ignored while busy=1
- oe  input  1  1 = storage outputs enabled; g_n = ~oe, registered, one-cycle latency
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  one-cycle pulse when a frame or clear completes
- si  output  1  serial data to the first stage
- sck  output  1  shift clock to the chain
- rck  output  1  storage latch clock to the chain
- sclr_n  output  1  shift-register clear to the chain, active low
- g_n  output  1  output enable to the chain, active low

Behaviour:
- Reset (rst_n=0), asynchronous, regardless of state:
  - state=IDLE; busy=0, done=0, si=0, sck=0, rck=0.
  - sclr_n=0 (chain held cleared while in reset); g_n=1 (outputs hi-Z).
  - First clk edge after release: sclr_n=1, g_n=~oe.
  - A reset mid-frame abandons the frame; no rck pulse is issued.
- All outputs are registered and glitch-free. Internal counters: phase (0..CLK_DIV-1), bit index (0..W-1).
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH_HI, LATCH_LO, CLEAR, DONE.
- IDLE:
  - If clr_req=1 at an edge, go to CLEAR. clr_req has priority over a simultaneous start.
  - Else if start=1, capture data into the shift buffer, set bit=W-1, go to SHIFT_LO.
  - busy rises on the edge that leaves IDLE.
- SHIFT_LO (CLK_DIV cycles): si=buf[bit], sck=0.
- SHIFT_HI (CLK_DIV cycles): sck=1, si held stable.
- Bit sequencing:
  - After SHIFT_HI, if bit>0: decrement bit and return to SHIFT_LO.
  - If bit=0: go to LATCH_HI.
  - data[W-1] is shifted first and ends in the far stage's QH; data[0] ends in the first stage's QA.
- LATCH_HI (CLK_DIV cycles): sck=0, rck=1. LATCH_LO (CLK_DIV cycles): rck=0. Then DONE.
- CLEAR:
  - sclr_n=0 for CLK_DIV cycles, then sclr_n=1.
  - Then LATCH_HI/LATCH_LO, so the zeros reach the storage outputs. Then DONE.
- DONE, one cycle: done=1, busy=0, si=0, then IDLE. start accepted in the DONE cycle is ignored; earliest restart is the following cycle.
- Frame timing, with start accepted at edge k:
  - sck rising edges at k+1+CLK_DIV+2*CLK_DIV*i, for i=0..W-1.
  - rck rises at k+1+2*CLK_DIV*W and falls CLK_DIV later.
  - done=1 at k+1+2*CLK_DIV*W+2*CLK_DIV.
  - Setup/hold: si changes only when sck falls or at SHIFT_LO entry, giving CLK_DIV cycles of setup and hold around each sck rise.
- Clear timing, with clr_req accepted at edge k: sclr_n low k+1..k+CLK_DIV, rck high for CLK_DIV cycles, done at k+1+3*CLK_DIV.
- g_n is independent of the state machine and follows oe at all times except during reset.
- data changing while busy has no effect; the buffer is captured once.

Test Plan:
- Reset: hold rst_n=0 with oe=1 → sclr_n=0, g_n=1, sck=rck=busy=0. Release → next edge sclr_n=1, g_n=0.
- N_CHIPS=1, CLK_DIV=2, data=8'hA5, start at k:
  - 8 sck rises at k+3, k+7, …, k+31; si at the rises = 1,0,1,0,0,1,0,1.
  - rck high k+33..k+34; done at k+37. A behavioural 595 model shows QH..QA=8'hA5.
- N_CHIPS=2, CLK_DIV=1, data=16'h8001:
  - 16 sck pulses; far stage storage = 8'h80, near stage = 8'h01.
  - busy high for exactly 2*16+2 cycles before done.
- start and clr_req both high in IDLE → CLEAR runs (sclr_n low CLK_DIV cycles, one rck pulse, no sck). Storage model reads 0.
- start pulses mid-frame and in the DONE cycle → ignored: exactly W sck pulses per accepted frame, one done per frame.
- rst_n asserted at the 5th sck rise of a frame → outputs at reset values immediately, no rck pulse, storage model unchanged. A new start after release completes normally.
